// File: rtl/jpeg_rle_symbolizer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | jpeg_rle_symbolizer                                                        |
// | Zigzag coefficients in, JPEG DC-diff / (run,size,amp) / ZRL / EOB out.     |
// | Optional macro: DC_PRED_RESTART_EN (adds dc_restart predictor clear).      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module jpeg_rle_symbolizer #(
    parameter int COEF_W = 12,
    parameter int AMP_W  = COEF_W + 1
) (
    input  logic              clk,
    input  logic              rst,
`ifdef DC_PRED_RESTART_EN
    input  logic              dc_restart,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COEF_W-1:0] in_coef,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_run,
    output logic [3:0]        out_size,
    output logic [AMP_W-1:0]  out_amp,
    output logic              out_is_dc,
    output logic              out_last
);

    localparam logic [1:0]       S_ACCEPT   = 2'd0;
    localparam logic [1:0]       S_ZRL      = 2'd1;
    localparam logic [1:0]       S_EMIT     = 2'd2;
    localparam logic [5:0]       c_IDX_LAST = 6'd63;
    localparam logic [5:0]       c_RUN_ZRL  = 6'd16;
    localparam logic [AMP_W-1:0] c_AMP_ONE  = AMP_W'(1);

    logic [1:0]        r_state;
    logic [5:0]        r_idx;
    logic [5:0]        r_run;
    logic [COEF_W-1:0] r_dc_pred;
    logic [COEF_W-1:0] r_held_coef;
    logic              r_held_last;

    logic              r_out_valid;
    logic [3:0]        r_out_run;
    logic [3:0]        r_out_size;
    logic [AMP_W-1:0]  r_out_amp;
    logic              r_out_is_dc;
    logic              r_out_last;

    logic              w_load_ok;
    logic              w_in_fire;
    logic              w_dc_fire;
    logic [COEF_W-1:0] w_pred_eff;
    logic [AMP_W-1:0]  w_coef_ext;
    logic [AMP_W-1:0]  w_pred_ext;
    logic [AMP_W-1:0]  w_held_ext;
    logic [AMP_W-1:0]  w_diff;
    logic [5:0]        w_run_sub;

    logic              w_emit;
    logic              w_zero_sym;
    logic              w_hold;
    logic [3:0]        w_run;
    logic [AMP_W-1:0]  w_src;
    logic              w_is_dc;
    logic              w_last;
    logic [3:0]        w_size;
    logic [AMP_W-1:0]  w_amp;
    logic [1:0]        w_next_state;
    logic [5:0]        w_next_run;

    // Bit length of |v|; v is a two's-complement AMP_W value.
    function automatic logic [3:0] f_size(input logic [AMP_W-1:0] v);
        logic [AMP_W-1:0] mag;
        logic [3:0]       s;
        mag = v[AMP_W-1] ? (~v + c_AMP_ONE) : v;
        s   = 4'd0;
        for (int i = 0; i < AMP_W; i++) begin
            if (mag[i]) begin
                s = 4'(i + 1);
            end
        end
        return s;
    endfunction

    // Negative values take the low bits of v-1, i.e. the ones' complement of |v|.
    function automatic logic [AMP_W-1:0] f_amp(input logic [AMP_W-1:0] v,
                                               input logic [3:0]       s);
        logic [AMP_W-1:0] base;
        logic [AMP_W-1:0] mask;
        base = v[AMP_W-1] ? (v - c_AMP_ONE) : v;
        mask = ~({AMP_W{1'b1}} << s);
        return base & mask;
    endfunction

`ifdef DC_PRED_RESTART_EN
    assign w_pred_eff = dc_restart ? '0 : r_dc_pred;
`else
    assign w_pred_eff = r_dc_pred;
`endif

    assign w_load_ok  = !r_out_valid || out_ready;
    assign in_ready   = (r_state == S_ACCEPT) && w_load_ok;
    assign w_in_fire  = in_valid && in_ready;
    assign w_dc_fire  = w_in_fire && (r_idx == 6'd0);

    assign w_coef_ext = {{(AMP_W-COEF_W){in_coef[COEF_W-1]}}, in_coef};
    assign w_pred_ext = {{(AMP_W-COEF_W){w_pred_eff[COEF_W-1]}}, w_pred_eff};
    assign w_held_ext = {{(AMP_W-COEF_W){r_held_coef[COEF_W-1]}}, r_held_coef};
    assign w_diff     = w_coef_ext - w_pred_ext;
    assign w_run_sub  = r_run - c_RUN_ZRL;

    always_comb begin
        w_emit       = 1'b0;
        w_zero_sym   = 1'b0;
        w_hold       = 1'b0;
        w_run        = 4'd0;
        w_src        = w_diff;
        w_is_dc      = 1'b0;
        w_last       = 1'b0;
        w_next_state = r_state;
        w_next_run   = r_run;
        case (r_state)
            S_ACCEPT: begin
                if (w_in_fire) begin
                    if (r_idx == 6'd0) begin
                        w_emit     = 1'b1;
                        w_is_dc    = 1'b1;
                        w_next_run = 6'd0;
                    end else if (in_coef == '0) begin
                        // A run still pending at the last index collapses into EOB.
                        if (r_idx == c_IDX_LAST) begin
                            w_emit     = 1'b1;
                            w_zero_sym = 1'b1;
                            w_last     = 1'b1;
                            w_next_run = 6'd0;
                        end else begin
                            w_next_run = r_run + 6'd1;
                        end
                    end else if (r_run < c_RUN_ZRL) begin
                        w_emit     = 1'b1;
                        w_run      = r_run[3:0];
                        w_src      = w_coef_ext;
                        w_last     = (r_idx == c_IDX_LAST);
                        w_next_run = 6'd0;
                    end else begin
                        w_hold       = 1'b1;
                        w_next_state = S_ZRL;
                    end
                end
            end
            S_ZRL: begin
                if (w_load_ok) begin
                    w_emit     = 1'b1;
                    w_zero_sym = 1'b1;
                    w_run      = 4'd15;
                    w_next_run = w_run_sub;
                    if (w_run_sub < c_RUN_ZRL) begin
                        w_next_state = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (w_load_ok) begin
                    w_emit       = 1'b1;
                    w_run        = r_run[3:0];
                    w_src        = w_held_ext;
                    w_last       = r_held_last;
                    w_next_run   = 6'd0;
                    w_next_state = S_ACCEPT;
                end
            end
            default: begin
                w_next_state = S_ACCEPT;
                w_next_run   = 6'd0;
            end
        endcase
    end

    assign w_size = w_zero_sym ? 4'd0 : f_size(w_src);
    assign w_amp  = w_zero_sym ? '0 : f_amp(w_src, w_size);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_ACCEPT;
            r_idx       <= 6'd0;
            r_run       <= 6'd0;
            r_dc_pred   <= '0;
            r_held_coef <= '0;
            r_held_last <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_run   <= w_next_run;
            if (w_in_fire) begin
                r_idx <= r_idx + 6'd1;
            end
            if (w_dc_fire) begin
                r_dc_pred <= in_coef;
`ifdef DC_PRED_RESTART_EN
            end else if (dc_restart) begin
                r_dc_pred <= '0;
`endif
            end
            if (w_hold) begin
                r_held_coef <= in_coef;
                r_held_last <= (r_idx == c_IDX_LAST);
            end
        end
    end

    // Single-slot output register: a new load may replace a symbol being taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_run   <= 4'd0;
            r_out_size  <= 4'd0;
            r_out_amp   <= '0;
            r_out_is_dc <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_emit) begin
            r_out_valid <= 1'b1;
            r_out_run   <= w_run;
            r_out_size  <= w_size;
            r_out_amp   <= w_amp;
            r_out_is_dc <= w_is_dc;
            r_out_last  <= w_last;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_run   = r_out_run;
    assign out_size  = r_out_size;
    assign out_amp   = r_out_amp;
    assign out_is_dc = r_out_is_dc;
    assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_jpeg_rle_symbolizer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_jpeg_rle_symbolizer                                                     |
// | Directed-vector bench for jpeg_rle_symbolizer (default build).             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_jpeg_rle_symbolizer;

    localparam int COEF_W = 12;
    localparam int AMP_W  = 13;

    typedef logic [AMP_W+9:0] sym_t;   // {is_dc, run, size, amp, last}

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [COEF_W-1:0] in_coef;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_run;
    logic [3:0]        out_size;
    logic [AMP_W-1:0]  out_amp;
    logic              out_is_dc;
    logic              out_last;

    int   n_pass  = 0;
    int   n_total = 0;
    int   stall_cnt;
    sym_t q[$];
    sym_t exp_q[$];
    logic [COEF_W-1:0] blk[64];

    jpeg_rle_symbolizer #(.COEF_W(COEF_W), .AMP_W(AMP_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_coef  (in_coef),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_run  (out_run),
        .out_size (out_size),
        .out_amp  (out_amp),
        .out_is_dc(out_is_dc),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready)
            q.push_back({out_is_dc, out_run, out_size, out_amp, out_last});
    end

    function automatic sym_t mk(input logic dc, input int run, input int size,
                                input int amp, input logic last);
        return {dc, 4'(run), 4'(size), AMP_W'(amp), last};
    endfunction

    function automatic void clear_blk();
        for (int i = 0; i < 64; i++) blk[i] = '0;
    endfunction

    task automatic send_block(input int n);
        logic acc;
        int   budget;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_coef  = blk[i];
            acc      = 1'b0;
            budget   = 0;
            while (!acc && budget < 200) begin
                @(negedge clk);
                acc = in_ready;
                if (!acc) stall_cnt++;
                @(posedge clk);
                #1;
                budget++;
            end
            if (!acc) begin
                n_total++;
                $display("FAIL accept_timeout idx=%0d", i);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_syms(input int n);
        int budget = 0;
        while (q.size() < n && budget < 300) begin
            @(posedge clk);
            budget++;
        end
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_coef = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", out_valid); else n_pass++;
        n_total++; if ({out_run, out_size, out_amp} !== '0) $display("FAIL rst_out_fields got %h exp 0", {out_run, out_size, out_amp}); else n_pass++;
        n_total++; if ({out_is_dc, out_last} !== 2'b00) $display("FAIL rst_flags got %b exp 00", {out_is_dc, out_last}); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", in_ready); else n_pass++;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_dc_first;
        clear_blk(); blk[0] = 12'd5; q.delete();
        exp_q = '{mk(1, 0, 3, 5, 0), mk(0, 0, 0, 0, 1)};
        send_block(64); wait_syms(exp_q.size());
        n_total++; if (q.size() != exp_q.size()) $display("FAIL dc_first_count got %0d exp %0d", q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            n_total++;
            if (i >= q.size() || q[i] !== exp_q[i]) $display("FAIL dc_first_sym%0d got %h exp %h", i, (i < q.size()) ? q[i] : '1, exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_dc_diff;
        clear_blk(); blk[0] = 12'd3; q.delete();
        exp_q = '{mk(1, 0, 2, 1, 0), mk(0, 0, 0, 0, 1)};
        send_block(64); wait_syms(exp_q.size());
        n_total++; if (q.size() != exp_q.size()) $display("FAIL dc_diff_count got %0d exp %0d", q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            n_total++;
            if (i >= q.size() || q[i] !== exp_q[i]) $display("FAIL dc_diff_sym%0d got %h exp %h", i, (i < q.size()) ? q[i] : '1, exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_zrl;
        clear_blk(); blk[0] = 12'd3; blk[21] = 12'd7; q.delete(); stall_cnt = 0;
        exp_q = '{mk(1, 0, 0, 0, 0), mk(0, 15, 0, 0, 0), mk(0, 4, 3, 7, 0), mk(0, 0, 0, 0, 1)};
        send_block(64); wait_syms(exp_q.size());
        n_total++; if (stall_cnt != 2) $display("FAIL zrl_stall_cycles got %0d exp 2", stall_cnt); else n_pass++;
        n_total++; if (q.size() != exp_q.size()) $display("FAIL zrl_count got %0d exp %0d", q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            n_total++;
            if (i >= q.size() || q[i] !== exp_q[i]) $display("FAIL zrl_sym%0d got %h exp %h", i, (i < q.size()) ? q[i] : '1, exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_trailing_zrl;
        clear_blk(); blk[0] = 12'd3; blk[63] = 12'hFFF; q.delete();
        exp_q = '{mk(1, 0, 0, 0, 0), mk(0, 15, 0, 0, 0), mk(0, 15, 0, 0, 0),
                  mk(0, 15, 0, 0, 0), mk(0, 14, 1, 0, 1)};
        send_block(64);
        @(negedge clk);
        n_total++; if (in_ready !== 1'b0) $display("FAIL tzrl_in_ready got %b exp 0", in_ready); else n_pass++;
        wait_syms(exp_q.size());
        n_total++; if (q.size() != exp_q.size()) $display("FAIL tzrl_count got %0d exp %0d", q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            n_total++;
            if (i >= q.size() || q[i] !== exp_q[i]) $display("FAIL tzrl_sym%0d got %h exp %h", i, (i < q.size()) ? q[i] : '1, exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure;
        sym_t snap;
        clear_blk(); blk[0] = 12'd10; blk[1] = 12'd1; blk[2] = 12'd2; blk[3] = 12'd3;
        blk[6] = 12'hFFC; q.delete();
        exp_q = '{mk(1, 0, 3, 7, 0), mk(0, 0, 1, 1, 0), mk(0, 0, 2, 2, 0),
                  mk(0, 0, 2, 3, 0), mk(0, 2, 3, 3, 0), mk(0, 0, 0, 0, 1)};
        fork
            send_block(64);
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (k == 0) begin
                        snap = {out_is_dc, out_run, out_size, out_amp, out_last};
                        n_total++; if (out_valid !== 1'b1) $display("FAIL bp_valid got %b exp 1", out_valid); else n_pass++;
                    end else begin
                        n_total++;
                        if ({out_is_dc, out_run, out_size, out_amp, out_last} !== snap)
                            $display("FAIL bp_stable%0d got %h exp %h", k, {out_is_dc, out_run, out_size, out_amp, out_last}, snap);
                        else n_pass++;
                    end
                    n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready%0d got %b exp 0", k, in_ready); else n_pass++;
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        wait_syms(exp_q.size());
        n_total++; if (q.size() != exp_q.size()) $display("FAIL bp_count got %0d exp %0d", q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            n_total++;
            if (i >= q.size() || q[i] !== exp_q[i]) $display("FAIL bp_sym%0d got %h exp %h", i, (i < q.size()) ? q[i] : '1, exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midblock;
        clear_blk(); blk[0] = 12'd7;
        for (int i = 1; i <= 30; i++) blk[i] = 12'd1;
        send_block(31);
        n_total++; if (out_valid !== 1'b1) $display("FAIL mid_pre_valid got %b exp 1", out_valid); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL mid_async_clear got %b exp 0", out_valid); else n_pass++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_blk(); blk[0] = 12'hFFB; q.delete();
        exp_q = '{mk(1, 0, 3, 2, 0), mk(0, 0, 0, 0, 1)};
        send_block(64); wait_syms(exp_q.size());
        n_total++; if (q.size() != exp_q.size()) $display("FAIL mid_count got %0d exp %0d", q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            n_total++;
            if (i >= q.size() || q[i] !== exp_q[i]) $display("FAIL mid_sym%0d got %h exp %h", i, (i < q.size()) ? q[i] : '1, exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_extremes;
        clear_blk(); blk[0] = 12'h800; blk[1] = 12'h7FF; blk[17] = 12'h800; q.delete();
        exp_q = '{mk(1, 0, 11, 4, 0), mk(0, 0, 11, 2047, 0), mk(0, 15, 12, 2047, 0), mk(0, 0, 0, 0, 1)};
        send_block(64); wait_syms(exp_q.size());
        n_total++; if (q.size() != exp_q.size()) $display("FAIL ext_count got %0d exp %0d", q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            n_total++;
            if (i >= q.size() || q[i] !== exp_q[i]) $display("FAIL ext_sym%0d got %h exp %h", i, (i < q.size()) ? q[i] : '1, exp_q[i]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_dc_first();
        test_dc_diff();
        test_zrl();
        test_trailing_zrl();
        test_backpressure();
        test_reset_midblock();
        test_extremes();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jpeg_rle_symbolizer.md
Name: jpeg_rle_symbolizer

Overview:
- Entropy front end of the JPEG encode path. Sits directly upstream of the Huffman/bit-packing timing cone.
- Accepts quantized coefficients in zigzag order, 64 per block, over a valid/ready handshake.
- Emits JPEG run/size/amplitude symbols, one per output handshake: a DC differential, AC (run,size) pairs, ZRL and EOB.

Parameters:
- COEF_W, 12, signed quantized coefficient width.
- AMP_W, COEF_W+1, amplitude and DC-difference width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  coefficient valid.
- in_ready  output  1  coefficient accepted when in_valid && in_ready.
- in_coef  input  COEF_W  signed coefficient, zigzag order.
- out_valid  output  1  symbol valid.
- out_ready  input  1  downstream accepts symbol.
- out_run  output  4  zero run preceding the coefficient (0 for DC/EOB, 15 for ZRL).
- out_size  output  4  magnitude category, 0..AMP_W.
- out_amp  output  AMP_W  amplitude bits, right-aligned, upper bits zero.
- out_is_dc  output  1  symbol is the DC differential.
- out_last  output  1  final symbol of the block.
- dc_restart  input  1  present only with DC_PRED_RESTART_EN.

Behaviour:
- Reset (async, immediate) clears:
  - out_valid=0, out_run=0, out_size=0, out_amp=0, out_is_dc=0, out_last=0.
  - idx=0, run=0, dc_pred=0, held coefficient cleared.
  - state=ACCEPT.
- A reset mid-block discards the partial block. The next accepted coefficient is DC of a new block.
- Output register is a single slot. Load is allowed when !out_valid || out_ready.
- States:
  - ACCEPT: in_ready = load-allowed. Each accepted coefficient does the following:
    - idx==0: diff = coef - dc_pred, computed at AMP_W bits. Emit {run 0, size(diff), amp(diff), is_dc=1}. dc_pred <= coef.
    - idx 1..63, coef==0: run++. No symbol, except idx==63, which emits EOB {0,0,0} with last=1.
    - idx 1..63, coef!=0, run<16: emit {run, size, amp}. run <= 0.
    - idx 1..63, coef!=0, run>=16: hold the coefficient, go to ZRL. No symbol this cycle.
    - last=1 when idx==63. idx wraps 63->0.
  - ZRL: in_ready=0. On each load-allowed cycle:
    - Emit {15,0,0}, run -= 16.
    - When run<16 after the subtract, go to EMIT.
  - EMIT: in_ready=0. On load-allowed, emit the held coefficient {run, size, amp, last=(held idx==63)}, then run <= 0, go to ACCEPT.
- Latency: a symbol is valid the cycle after its coefficient is accepted, when not stalled.
- Trailing zeros never produce ZRL. A pending run at idx 63 collapses into EOB.
- Size: bit length of |v|; size(0)=0.
- Amplitude:
  - v>0: low size bits of v.
  - v<0: low size bits of (v-1), i.e. the ones' complement of |v|.
- Simultaneous events:
  - A load and out_ready in the same cycle replaces the symbol with no bubble.
  - out_* hold stable while out_valid && !out_ready.
- dc_pred persists across blocks until reset.

Optional Feature:
- DC_PRED_RESTART_EN defined:
  - dc_restart port exists. A pulse clears dc_pred to 0 at the next clock edge.
  - If the pulse coincides with an idx==0 accept, the diff uses pred=0.
  - A pulse mid-block does not affect the block in flight.
- Undefined: the port is absent; the predictor clears only on rst.

Test Plan:
- Block 1 = [5, 63×0] from reset -> {dc,0,3,3'b101}, then EOB {0,0,0,last=1}. Two symbols total.
- Block 2 = [3, 63×0] after block 1 -> diff -2 -> {dc,0,2,2'b01}, then EOB last.
- Block with idx1..20 = 0, idx21 = 7, rest 0 -> DC, ZRL{15,0,0}, {4,3,3'b111}, EOB. in_ready=0 for the ZRL/EMIT cycles.
- Block with idx1..62 = 0, idx63 = -1 -> DC, ZRL×3, {14,1,1'b0,last=1}. No EOB.
- out_ready held 0 for 5 cycles mid-block -> out_* stable, in_ready=0, no symbol lost or duplicated. Totals match the reference model.
- rst asserted at idx 30 with out_valid=1 -> out_valid=0 immediately. The next block's DC diff uses pred=0.
